// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: round-robin with
// a bounded lock, combinational grant, and a one-cycle-latency read return path.
module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_ni,

  input  logic        r0_req_i,
  input  logic        r0_we_i,
  input  logic        r0_lock_i,
  input  logic [15:0] r0_addr_i,
  input  logic [15:0] r0_wdata_i,
  output logic        r0_gnt_o,
  output logic        r0_rvalid_o,
  output logic [15:0] r0_rdata_o,

  input  logic        r1_req_i,
  input  logic        r1_we_i,
  input  logic        r1_lock_i,
  input  logic [15:0] r1_addr_i,
  input  logic [15:0] r1_wdata_i,
  output logic        r1_gnt_o,
  output logic        r1_rvalid_o,
  output logic [15:0] r1_rdata_o,

  output logic [15:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);

  localparam logic [7:0] LockMax = 8'(LOCK_MAX);

  // Requester encoding: 1'b0 = r0, 1'b1 = r1.
  logic       last_gnt_q, last_gnt_d;
  logic       lock_vld_q, lock_vld_d;
  logic       lock_own_q, lock_own_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       r0_rvalid_q, r0_rvalid_d;
  logic       r1_rvalid_q, r1_rvalid_d;

  logic contended;
  logic lock_expired;
  logic lock_break;
  logic any_gnt;
  logic win;
  logic win_lock;
  logic win_we;

  assign contended    = r0_req_i & r1_req_i;
  assign lock_expired = (lock_cnt_q >= LockMax);
  assign lock_break   = contended & lock_vld_q & lock_expired;

  // Winner selection; all grants are suppressed while reset is asserted.
  always_comb begin
    any_gnt = 1'b0;
    win     = 1'b0;
    if (reset_ni) begin
      if (contended) begin
        any_gnt = 1'b1;
        if (lock_vld_q && !lock_expired) begin
          win = lock_own_q;
        end else if (lock_vld_q) begin
          win = ~lock_own_q;
        end else begin
          win = ~last_gnt_q;
        end
      end else if (r0_req_i) begin
        any_gnt = 1'b1;
        win     = 1'b0;
      end else if (r1_req_i) begin
        any_gnt = 1'b1;
        win     = 1'b1;
      end
    end
  end

  assign r0_gnt_o = any_gnt & ~win;
  assign r1_gnt_o = any_gnt &  win;

  always_comb begin
    mem_addr_o  = 16'h0000;
    mem_wdata_o = 16'h0000;
    win_we      = 1'b0;
    win_lock    = 1'b0;
    if (any_gnt) begin
      if (win) begin
        mem_addr_o  = r1_addr_i;
        mem_wdata_o = r1_wdata_i;
        win_we      = r1_we_i;
        win_lock    = r1_lock_i;
      end else begin
        mem_addr_o  = r0_addr_i;
        mem_wdata_o = r0_wdata_i;
        win_we      = r0_we_i;
        win_lock    = r0_lock_i;
      end
    end
  end

  assign mem_we_o = any_gnt & win_we;

  // Lock ownership lasts exactly one cycle past a locked grant; the counter only
  // advances while the other side is actually waiting.
  always_comb begin
    last_gnt_d = last_gnt_q;
    lock_vld_d = 1'b0;
    lock_own_d = lock_own_q;
    lock_cnt_d = 8'h00;
    if (any_gnt) begin
      last_gnt_d = win;
      if (win_lock && !lock_break) begin
        lock_vld_d = 1'b1;
        lock_own_d = win;
        if (lock_vld_q && (lock_own_q == win)) begin
          lock_cnt_d = (contended && (lock_cnt_q != 8'hFF)) ? lock_cnt_q + 8'h01 : lock_cnt_q;
        end else begin
          lock_cnt_d = contended ? 8'h01 : 8'h00;
        end
      end
    end
  end

  assign r0_rvalid_d = r0_gnt_o & ~r0_we_i;
  assign r1_rvalid_d = r1_gnt_o & ~r1_we_i;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      last_gnt_q  <= 1'b1;
      lock_vld_q  <= 1'b0;
      lock_own_q  <= 1'b0;
      lock_cnt_q  <= 8'h00;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      lock_vld_q  <= lock_vld_d;
      lock_own_q  <= lock_own_d;
      lock_cnt_q  <= lock_cnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
    end
  end

  assign r0_rvalid_o = r0_rvalid_q;
  assign r1_rvalid_o = r1_rvalid_q;
  assign r0_rdata_o  = r0_rvalid_q ? mem_rdata_i : 16'h0000;
  assign r1_rdata_o  = r1_rvalid_q ? mem_rdata_i : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural arbitration model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int unsigned LockMax = 8;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  mem_arbiter #(.LOCK_MAX(LockMax)) dut (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .r0_req_i    (r0_req),
    .r0_we_i     (r0_we),
    .r0_lock_i   (r0_lock),
    .r0_addr_i   (r0_addr),
    .r0_wdata_i  (r0_wdata),
    .r0_gnt_o    (r0_gnt),
    .r0_rvalid_o (r0_rvalid),
    .r0_rdata_o  (r0_rdata),
    .r1_req_i    (r1_req),
    .r1_we_i     (r1_we),
    .r1_lock_i   (r1_lock),
    .r1_addr_i   (r1_addr),
    .r1_wdata_i  (r1_wdata),
    .r1_gnt_o    (r1_gnt),
    .r1_rvalid_o (r1_rvalid),
    .r1_rdata_o  (r1_rdata),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Memory environment: synchronous write, one-cycle read latency.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: who was granted last, who holds the lock (-1 none), lock count,
  // and the read responses due in the current cycle.
  int          m_last, m_own, m_cnt;
  bit          m_rv [2];
  logic [15:0] m_rd [2];

  task automatic model_reset();
    m_last = 1; m_own = -1; m_cnt = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
  endtask

  function automatic int exp_win();
    if (!reset_ni) return -1;
    if (r0_req && r1_req) begin
      if (m_own >= 0) return (m_cnt < LockMax) ? m_own : 1 - m_own;
      return 1 - m_last;
    end
    if (r0_req) return 0;
    if (r1_req) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    bit both, lk, we;
    logic [15:0] a;
    if (reset_ni) begin
      g    = exp_win();
      both = r0_req && r1_req;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (g < 0) begin
        m_own = -1; m_cnt = 0;
      end else begin
        lk = (g == 1) ? r1_lock : r0_lock;
        we = (g == 1) ? r1_we : r0_we;
        a  = (g == 1) ? r1_addr : r0_addr;
        if (!lk || (both && m_own >= 0 && m_cnt >= LockMax)) begin
          m_own = -1; m_cnt = 0;
        end else if (m_own == g) begin
          if (both && m_cnt < 255) m_cnt = m_cnt + 1;
        end else begin
          m_own = g; m_cnt = both ? 1 : 0;
        end
        m_last = g;
        if (!we) begin
          m_rv[g] = 1'b1;
          m_rd[g] = mem[a[7:0]];
        end
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    int g;
    logic [15:0] ea, ed;
    logic ew;
    if (chk_on) begin
      g  = exp_win();
      ea = 16'h0; ed = 16'h0; ew = 1'b0;
      if (g == 0) begin ea = r0_addr; ed = r0_wdata; ew = r0_we; end
      if (g == 1) begin ea = r1_addr; ed = r1_wdata; ew = r1_we; end
      chk("m_gnt0", 16'(r0_gnt), 16'(g == 0));
      chk("m_gnt1", 16'(r1_gnt), 16'(g == 1));
      chk("m_mem_addr", mem_addr, ea);
      chk("m_mem_wdata", mem_wdata, ed);
      chk("m_mem_we", 16'(mem_we), 16'(ew));
      chk("m_rvalid0", 16'(r0_rvalid), 16'(m_rv[0]));
      chk("m_rvalid1", 16'(r1_rvalid), 16'(m_rv[1]));
      chk("m_rdata0", r0_rdata, m_rv[0] ? m_rd[0] : 16'h0);
      chk("m_rdata1", r1_rdata, m_rv[1] ? m_rd[1] : 16'h0);
    end
  end

  task automatic drv0(input bit req, input bit we, input bit lock, input logic [15:0] a,
                      input logic [15:0] d);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drv1(input bit req, input bit we, input bit lock, input logic [15:0] a,
                      input logic [15:0] d);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = a; r1_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
    mem[16] = 16'h1234;
    reset_ni = 1'b0;
    model_reset();
    // Requests present during reset must be ignored.
    drv0(1, 0, 0, 16'h0010, 16'h0);
    drv1(1, 1, 0, 16'h0020, 16'hBEEF);
    chk_on = 1'b1;
    at_neg();
    chk("rst_gnt0", 16'(r0_gnt), 16'h0);
    chk("rst_gnt1", 16'(r1_gnt), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_rvalid0", 16'(r0_rvalid), 16'h0);

    tick();
    reset_ni = 1'b1;
    drv0(0, 0, 0, 16'h00FF, 16'h1111);
    drv1(0, 1, 0, 16'h00EE, 16'h2222);
    at_neg();
    chk("idle_mem_addr", mem_addr, 16'h0);
    chk("idle_mem_wdata", mem_wdata, 16'h0);
    chk("idle_mem_we", 16'(mem_we), 16'h0);

    // Single read from r0.
    tick();
    drv0(1, 0, 0, 16'h0010, 16'h0);
    at_neg();
    chk("rd_gnt0", 16'(r0_gnt), 16'h1);
    chk("rd_mem_addr", mem_addr, 16'h0010);
    tick();
    drv0(0, 0, 0, 16'h0, 16'h0);
    at_neg();
    chk("rd_rvalid0", 16'(r0_rvalid), 16'h1);
    chk("rd_rdata0", r0_rdata, 16'h1234);
    chk("rd_rvalid1", 16'(r1_rvalid), 16'h0);

    // Single write from r1.
    tick();
    drv1(1, 1, 0, 16'h0020, 16'hBEEF);
    at_neg();
    chk("wr_gnt1", 16'(r1_gnt), 16'h1);
    chk("wr_mem_we", 16'(mem_we), 16'h1);
    chk("wr_mem_addr", mem_addr, 16'h0020);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    drv1(0, 0, 0, 16'h0, 16'h0);
    at_neg();
    chk("wr_rvalid0", 16'(r0_rvalid), 16'h0);
    chk("wr_rvalid1", 16'(r1_rvalid), 16'h0);

    // Continuous contention without lock alternates, r0 first.
    tick();
    drv0(1, 0, 0, 16'h0030, 16'h0);
    drv1(1, 0, 0, 16'h0040, 16'h0);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("rr_gnt0", 16'(r0_gnt), 16'((k % 2) == 0));
      tick();
    end

    // r0 locks under contention: eight grants, then r1.
    drv0(1, 0, 1, 16'h0031, 16'h0);
    for (int k = 0; k < 9; k++) begin
      at_neg();
      chk("lock0_gnt0", 16'(r0_gnt), 16'(k < 8));
      tick();
    end

    // r1 locks alone first (count holds), then eight contended grants.
    drv0(0, 0, 0, 16'h0, 16'h0);
    drv1(1, 0, 1, 16'h0041, 16'h0);
    for (int k = 0; k < 3; k++) tick();
    drv0(1, 1, 0, 16'h0032, 16'hCAFE);
    for (int k = 0; k < 9; k++) begin
      at_neg();
      chk("lock1_gnt1", 16'(r1_gnt), 16'(k < 8));
      tick();
    end

    // An idle cycle drops the lock; contention then reverts to round-robin.
    drv0(1, 0, 1, 16'h0033, 16'h0);
    drv1(1, 1, 0, 16'h0042, 16'h7777);
    for (int k = 0; k < 3; k++) tick();
    drv0(0, 0, 0, 16'h0, 16'h0);
    drv1(0, 0, 0, 16'h0, 16'h0);
    tick();
    drv0(1, 0, 0, 16'h0034, 16'h0);
    drv1(1, 0, 1, 16'h0043, 16'h0);
    for (int k = 0; k < 4; k++) tick();

    // Read granted, then reset: no late response and r0 wins next contention.
    drv0(0, 0, 0, 16'h0, 16'h0);
    drv1(0, 0, 0, 16'h0, 16'h0);
    tick();
    drv0(1, 0, 0, 16'h0010, 16'h0);
    at_neg();
    chk("rr_rd_gnt0", 16'(r0_gnt), 16'h1);
    tick();
    drv0(0, 0, 0, 16'h0, 16'h0);
    reset_ni = 1'b0;
    model_reset();
    at_neg();
    chk("rr_rvalid0", 16'(r0_rvalid), 16'h0);
    tick();
    reset_ni = 1'b1;
    drv0(1, 0, 0, 16'h0035, 16'h0);
    drv1(1, 0, 0, 16'h0044, 16'h0);
    at_neg();
    chk("rr_post_gnt0", 16'(r0_gnt), 16'h1);
    tick();
    drv0(0, 0, 0, 16'h0, 16'h0);
    drv1(0, 0, 0, 16'h0, 16'h0);
    tick();
    tick();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, 8, maximum consecutive locked grants to one requester while the other is requesting (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_ni  input  1  asynchronous, active-low reset.
REQ-004 r0_req_i  input  1  requester 0 access request; held until granted.
REQ-005 r0_we_i  input  1  requester 0 write (1) / read (0).
REQ-006 r0_lock_i  input  1  requester 0 asks to keep ownership for the next access.
REQ-007 r0_addr_i  input  16  requester 0 word address.
REQ-008 r0_wdata_i  input  16  requester 0 write data.
REQ-009 r0_gnt_o  output  1  requester 0 access accepted this cycle.
REQ-010 r0_rvalid_o  output  1  requester 0 read data valid.
REQ-011 r0_rdata_o  output  16  requester 0 read data.
REQ-012 r1_* ports SHALL mirror REQ-004..REQ-011 for requester 1.
REQ-013 mem_addr_o  output  16  shared data-memory address.
REQ-014 mem_we_o  output  1  shared data-memory write enable.
REQ-015 mem_wdata_o  output  16  shared data-memory write data.
REQ-016 mem_rdata_i  input  16  memory read data, valid one cycle after read address presented.

Function
REQ-017 At most one of r0_gnt_o/r1_gnt_o SHALL be high in any cycle; a grant SHALL be issued only to an asserted req, combinationally in the same cycle.
REQ-018 With no requests: both gnt 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0.
REQ-019 Granted requester's addr/we/wdata SHALL drive mem_* combinationally in the grant cycle; mem_we_o = we & gnt.
REQ-020 Arbitration: single requester wins; both requesting -> round-robin, the requester not granted most recently wins (registered last_gnt pointer).
REQ-021 Lock: if the previous cycle's grant had lock_i=1 and that requester requests again, it SHALL win regardless of round-robin, unless REQ-022 applies.
REQ-022 Lock counter (8-bit) SHALL count consecutive locked grants to the same owner while the other requester requests; on reaching LOCK_MAX the next contended cycle SHALL grant the other requester and clear lock ownership and counter.
REQ-023 Lock counter SHALL clear on any grant with lock_i=0, on owner change, or on a cycle with no grant.
REQ-024 Read response: for a read grant in cycle N, rvalid_o of that requester SHALL be 1 in cycle N+1 only, with rdata_o = mem_rdata_i; the other requester's rvalid 0.
REQ-025 rdata_o SHALL be 0 whenever its rvalid_o is 0.
REQ-026 Back-to-back grants (every cycle, either requester) SHALL be supported at full throughput; a read response in N+1 SHALL not block a grant in N+1.
REQ-027 Writes SHALL produce no rvalid.
REQ-028 last_gnt SHALL update only on cycles with a grant.

Reset
REQ-029 On reset_ni low, immediately: rvalid outputs 0, last_gnt = requester 1 (so requester 0 wins first contention), lock owner none, lock counter 0.
REQ-030 A read granted in the cycle before reset assertion SHALL produce no rvalid after reset release.
REQ-031 Combinational gnt/mem_* outputs SHALL be forced to 0 while reset_ni is low.

Verification
REQ-032 Reset, then r0 read addr 0x0010, mem returns 0x1234 -> r0_gnt_o=1 cycle N, r0_rvalid_o=1 and r0_rdata_o=0x1234 at N+1.
REQ-033 Both requesting continuously, lock 0 -> grants alternate r0,r1,r0,r1 starting with r0.
REQ-034 r1 write addr 0x0020 data 0xBEEF alone -> mem_we_o=1, mem_addr_o=0x0020, mem_wdata_o=0xBEEF, no rvalid.
REQ-035 r0 lock=1 with r1 requesting, LOCK_MAX=8 -> r0 granted 8 consecutive cycles, then r1 granted.
REQ-036 r0 read granted, reset_ni pulsed low next cycle -> r0_rvalid_o stays 0, next contention grants r0.
